// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage, directly downstream of the memory stage.
// It picks the writeback value (ALU result or load data), owns the architectural
// register file with two combinational read ports for decode, and publishes a
// registered forwarding bundle plus a retired-write counter.
//
// Build option: define WB_ZERO_REG_EN to hardwire register 0 to zero.
// Without that macro, register 0 is an ordinary writable register.
module writeback_stage #(
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              Wr_MEM,
    input  logic              Rm_MEM,
    input  logic [1:0]        rdmem,
    input  logic [DATA_W-1:0] acOutWb,
    input  logic [DATA_W-1:0] data_out,
    input  logic [1:0]        rs_addr,
    input  logic [1:0]        rt_addr,
    output logic [DATA_W-1:0] rs_val,
    output logic [DATA_W-1:0] rt_val,
    output logic              fwd_valid,
    output logic [1:0]        fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  wb_count
);

    // Architectural register file, indexed by the 2-bit register addresses.
    logic [DATA_W-1:0] regfile [NUM_REGS];

    // Raw writeback selection between load data and ALU result.
    logic [DATA_W-1:0] wb_value;

    // Value that actually becomes architectural (differs from wb_value only
    // when register 0 is hardwired to zero).
    logic [DATA_W-1:0] commit_value;

    // Whether this cycle's write lands in the register array.
    logic reg_write;

    // Same-cycle bypass is only meaningful outside reset: while reset is held
    // the registers must read as RESET_VAL, even if a write is being offered.
    logic bypass_en;

    assign wb_value  = Rm_MEM ? data_out : acOutWb;
    assign bypass_en = Wr_MEM && reset_n;

`ifdef WB_ZERO_REG_EN
    assign commit_value = (rdmem == 2'd0) ? '0 : wb_value;
    assign reg_write    = Wr_MEM && (rdmem != 2'd0);
`else
    assign commit_value = wb_value;
    assign reg_write    = Wr_MEM;
`endif

    // Register file update: reset clears every entry, otherwise write rdmem.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regfile[i] <= RESET_VAL;
            end
        end else if (reg_write) begin
            regfile[rdmem] <= commit_value;
        end
    end

    // Forwarding bundle: valid pulses for one cycle per write, payload holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fwd_valid <= 1'b0;
            fwd_rd    <= 2'd0;
            fwd_data  <= '0;
        end else if (Wr_MEM) begin
            fwd_valid <= 1'b1;
            fwd_rd    <= rdmem;
            fwd_data  <= commit_value;
        end else begin
            fwd_valid <= 1'b0;
        end
    end

    // Retired-write counter; wraps silently from all-ones back to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_count <= '0;
        end else if (Wr_MEM) begin
            wb_count <= wb_count + CNT_W'(1);
        end
    end

    // Read port A with write-through bypass of the write completing this cycle.
    always_comb begin
        rs_val = regfile[rs_addr];
        if (bypass_en && (rs_addr == rdmem)) begin
            rs_val = commit_value;
        end
`ifdef WB_ZERO_REG_EN
        if (rs_addr == 2'd0) begin
            rs_val = '0;
        end
`endif
    end

    // Read port B, identical rules to port A.
    always_comb begin
        rt_val = regfile[rt_addr];
        if (bypass_en && (rt_addr == rdmem)) begin
            rt_val = commit_value;
        end
`ifdef WB_ZERO_REG_EN
        if (rt_addr == 2'd0) begin
            rt_val = '0;
        end
`endif
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: self-checking bench for writeback_stage.
// Directed table of vectors, hand-written reset/wrap sequences, and random
// traffic checked against a behavioural register-file model.
// Honours WB_ZERO_REG_EN the same way the design does.
module tb_writeback_stage;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        Wr_MEM   = 1'b0;
    logic        Rm_MEM   = 1'b0;
    logic [1:0]  rdmem    = 2'd0;
    logic [7:0]  acOutWb  = 8'h00;
    logic [7:0]  data_out = 8'h00;
    logic [1:0]  rs_addr  = 2'd0;
    logic [1:0]  rt_addr  = 2'd0;
    logic [7:0]  rs_val;
    logic [7:0]  rt_val;
    logic        fwd_valid;
    logic [1:0]  fwd_rd;
    logic [7:0]  fwd_data;
    logic [15:0] wb_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Behavioural model state.
    bit [7:0]  m_regs [4];
    bit        m_fv;
    bit [1:0]  m_frd;
    bit [7:0]  m_fd;
    bit [15:0] m_cnt;

    typedef struct {
        bit        wr;
        bit        rm;
        bit [1:0]  rd;
        bit [7:0]  ac;
        bit [7:0]  dout;
        bit [1:0]  rs;
        bit [1:0]  rt;
        bit [7:0]  exp_rs;
        bit [7:0]  exp_rt;
        bit        exp_fv;
        bit [1:0]  exp_frd;
        bit [7:0]  exp_fd;
        bit [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    writeback_stage dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .Wr_MEM   (Wr_MEM),
        .Rm_MEM   (Rm_MEM),
        .rdmem    (rdmem),
        .acOutWb  (acOutWb),
        .data_out (data_out),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .fwd_valid(fwd_valid),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .wb_count (wb_count)
    );

    // 10-unit clock period.
    always #5 clock = ~clock;

    // An undriven write enable outside reset is an unsupported input.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && $isunknown(Wr_MEM)) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL wr_mem_known: got %b, required 0 or 1", Wr_MEM);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit wr, input bit rm, input bit [1:0] rd,
                                 input bit [7:0] ac, input bit [7:0] dout,
                                 input bit [1:0] rs, input bit [1:0] rt);
        Wr_MEM   = wr;
        Rm_MEM   = rm;
        rdmem    = rd;
        acOutWb  = ac;
        data_out = dout;
        rs_addr  = rs;
        rt_addr  = rt;
    endtask

    function automatic bit [7:0] model_wb(bit rm, bit [7:0] ac, bit [7:0] dout, bit [1:0] rd);
        bit [7:0] v;
        v = rm ? dout : ac;
`ifdef WB_ZERO_REG_EN
        if (rd == 2'd0) v = 8'h00;
`endif
        return v;
    endfunction

    function automatic bit [7:0] model_read(bit [1:0] addr, bit wr, bit [1:0] rd, bit [7:0] wbv);
        if (reset_n !== 1'b1) return 8'h00;
`ifdef WB_ZERO_REG_EN
        if (addr == 2'd0) return 8'h00;
`endif
        if (wr && addr == rd) return wbv;
        return m_regs[addr];
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_fv  = 1'b0;
        m_frd = 2'd0;
        m_fd  = 8'h00;
        m_cnt = 16'd0;
    endtask

    task automatic model_clock(bit wr, bit [1:0] rd, bit [7:0] wbv);
        if (wr) begin
`ifdef WB_ZERO_REG_EN
            if (rd != 2'd0) m_regs[rd] = wbv;
`else
            m_regs[rd] = wbv;
`endif
            m_fv  = 1'b1;
            m_frd = rd;
            m_fd  = wbv;
            m_cnt = m_cnt + 16'd1;
        end else begin
            m_fv = 1'b0;
        end
    endtask

    // One clocked transaction checked entirely against the model.
    task automatic run_cycle(input bit wr, input bit rm, input bit [1:0] rd,
                             input bit [7:0] ac, input bit [7:0] dout,
                             input bit [1:0] rs, input bit [1:0] rt);
        bit [7:0] wbv;
        applyStimulus(wr, rm, rd, ac, dout, rs, rt);
        wbv = model_wb(rm, ac, dout, rd);
        #1;
        checkOutput("rs_val", rs_val, model_read(rs, wr, rd, wbv));
        checkOutput("rt_val", rt_val, model_read(rt, wr, rd, wbv));
        @(posedge clock);
        model_clock(wr, rd, wbv);
        #1;
        checkOutput("fwd_valid", fwd_valid, m_fv);
        checkOutput("fwd_rd", fwd_rd, m_frd);
        checkOutput("fwd_data", fwd_data, m_fd);
        checkOutput("wb_count", wb_count, m_cnt);
    endtask

    initial begin
        int n_fill;

        vecs[0] = '{1'b1, 1'b0, 2'd2, 8'h5A, 8'hFF, 2'd2, 2'd0, 8'h5A, 8'h00, 1'b1, 2'd2, 8'h5A, 16'd1};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 2'd2, 2'd3, 8'h5A, 8'h00, 1'b0, 2'd2, 8'h5A, 16'd1};
        vecs[2] = '{1'b1, 1'b1, 2'd1, 8'h12, 8'hC3, 2'd1, 2'd1, 8'hC3, 8'hC3, 1'b1, 2'd1, 8'hC3, 16'd2};
        vecs[3] = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h99, 2'd1, 2'd2, 8'hC3, 8'h5A, 1'b0, 2'd1, 8'hC3, 16'd2};
        vecs[4] = '{1'b1, 1'b0, 2'd3, 8'h11, 8'h00, 2'd3, 2'd1, 8'h11, 8'hC3, 1'b1, 2'd3, 8'h11, 16'd3};
        vecs[5] = '{1'b1, 1'b0, 2'd3, 8'h22, 8'h00, 2'd3, 2'd3, 8'h22, 8'h22, 1'b1, 2'd3, 8'h22, 16'd4};
        vecs[6] = '{1'b0, 1'b0, 2'd3, 8'h00, 8'h00, 2'd3, 2'd2, 8'h22, 8'h5A, 1'b0, 2'd3, 8'h22, 16'd4};
        vecs[7] = '{1'b1, 1'b0, 2'd2, 8'hAA, 8'h00, 2'd2, 2'd1, 8'hAA, 8'hC3, 1'b1, 2'd2, 8'hAA, 16'd5};
        vecs[8] = '{1'b0, 1'b0, 2'd2, 8'h00, 8'h00, 2'd2, 2'd3, 8'hAA, 8'h22, 1'b0, 2'd2, 8'hAA, 16'd5};

        // Reset held with a write offered: nothing may land.
        applyStimulus(1'b1, 1'b0, 2'd2, 8'hEE, 8'hDD, 2'd2, 2'd2);
        repeat (3) @(posedge clock);
        #1;
        for (int a = 0; a < 4; a++) begin
            rs_addr = 2'(a);
            rt_addr = 2'(a);
            #1;
            checkOutput("reset_rs", rs_val, 8'h00);
            checkOutput("reset_rt", rt_val, 8'h00);
        end
        checkOutput("reset_fwd_valid", fwd_valid, 1'b0);
        checkOutput("reset_fwd_rd", fwd_rd, 2'd0);
        checkOutput("reset_fwd_data", fwd_data, 8'h00);
        checkOutput("reset_wb_count", wb_count, 16'd0);

        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 2'd0, 2'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();

        // Directed table; the first entry is the first write after release.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].rm, vecs[i].rd, vecs[i].ac,
                          vecs[i].dout, vecs[i].rs, vecs[i].rt);
            #1;
            checkOutput("tbl_rs_val", rs_val, vecs[i].exp_rs);
            checkOutput("tbl_rt_val", rt_val, vecs[i].exp_rt);
            @(posedge clock);
            model_clock(vecs[i].wr, vecs[i].rd,
                        model_wb(vecs[i].rm, vecs[i].ac, vecs[i].dout, vecs[i].rd));
            #1;
            checkOutput("tbl_fwd_valid", fwd_valid, vecs[i].exp_fv);
            checkOutput("tbl_fwd_rd", fwd_rd, vecs[i].exp_frd);
            checkOutput("tbl_fwd_data", fwd_data, vecs[i].exp_fd);
            checkOutput("tbl_wb_count", wb_count, vecs[i].exp_cnt);
        end

        // Register 0 behaviour depends on the build option.
        run_cycle(1'b1, 1'b0, 2'd0, 8'h77, 8'h00, 2'd0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 2'd0, 2'd0);
        #1;
`ifdef WB_ZERO_REG_EN
        checkOutput("r0_read", rs_val, 8'h00);
        checkOutput("r0_fwd_data", fwd_data, 8'h00);
`else
        checkOutput("r0_read", rs_val, 8'h77);
        checkOutput("r0_fwd_data", fwd_data, 8'h77);
`endif
        checkOutput("r0_wb_count", wb_count, 16'd6);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            run_cycle($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
                      8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom));
        end

        // Reset asserted mid-cycle while a write is pending.
        applyStimulus(1'b1, 1'b0, 2'd1, 8'h44, 8'h00, 2'd1, 2'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checkOutput("midrst_rs", rs_val, 8'h00);
        checkOutput("midrst_fwd_valid", fwd_valid, 1'b0);
        checkOutput("midrst_fwd_data", fwd_data, 8'h00);
        checkOutput("midrst_wb_count", wb_count, 16'd0);
        @(posedge clock);
        #1;
        checkOutput("midrst_hold_rs", rs_val, 8'h00);
        checkOutput("midrst_hold_count", wb_count, 16'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 2'd0, 2'd0);
        reset_n = 1'b1;
        run_cycle(1'b1, 1'b0, 2'd1, 8'h5E, 8'h00, 2'd1, 2'd0);
        checkOutput("post_rst_first_write", wb_count, 16'd1);

        // Counter wrap: fill to all-ones, then one more write.
        applyStimulus(1'b1, 1'b0, 2'd1, 8'h3C, 8'h00, 2'd2, 2'd3);
        n_fill = 16'hFFFF - int'(m_cnt);
        repeat (n_fill) @(posedge clock);
        model_clock(1'b1, 2'd1, 8'h3C);
        m_cnt = 16'hFFFF;
        #1;
        checkOutput("wrap_full", wb_count, 16'hFFFF);
        run_cycle(1'b1, 1'b0, 2'd1, 8'h3D, 8'h00, 2'd1, 2'd1);
        checkOutput("wrap_zero", wb_count, 16'd0);
        repeat (3) run_cycle(1'b0, 1'b1, 2'd2, 8'h00, 8'h55, 2'd1, 2'd2);
        checkOutput("wrap_idle_hold", wb_count, 16'd0);
        checkOutput("wrap_reg", rs_val, 8'h3D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
